// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined Booth multiplier.
//   sign_mode_e  : operand signedness, bit1 = multiplicand signed, bit0 = multiplier signed
//   booth_sel_e  : magnitude selected by one radix-4 Booth digit (0, 1x or 2x multiplicand)
//   MUL_LATENCY  : number of register stages between accept and result
package mul_pkg;

    localparam int MUL_LATENCY = 3;

    typedef enum logic [1:0] {
        UU = 2'b00,
        US = 2'b01,
        SU = 2'b10,
        SS = 2'b11
    } sign_mode_e;

    typedef enum logic [1:0] {
        BOOTH_ZERO = 2'b00,
        BOOTH_ONE  = 2'b01,
        BOOTH_TWO  = 2'b10
    } booth_sel_e;

    function automatic logic a_is_signed(input sign_mode_e mode);
        return (mode == SU) || (mode == SS);
    endfunction

    function automatic logic b_is_signed(input sign_mode_e mode);
        return (mode == US) || (mode == SS);
    endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder for a single digit.
//   triplet : multiplier bits {b[2j+1], b[2j], b[2j-1]}
//   sel     : magnitude of the digit (0, 1 or 2 times the multiplicand)
//   neg     : digit is negative
module booth_r4_enc
    import mul_pkg::*;
(
    input  logic [2:0] triplet,
    output booth_sel_e sel,
    output logic       neg
);

    // 3'b111 is -0; it is reported as a plain zero so no stray +1 is injected.
    always_comb begin
        sel = BOOTH_ZERO;
        neg = 1'b0;
        case (triplet)
            3'b001, 3'b010: sel = BOOTH_ONE;
            3'b011:         sel = BOOTH_TWO;
            3'b100: begin
                sel = BOOTH_TWO;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                sel = BOOTH_ONE;
                neg = 1'b1;
            end
            default: begin
                sel = BOOTH_ZERO;
                neg = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/carry_save_adder.sv
// 3:2 carry-save adder over a WIDTH-bit vector.
//   a, b, c : addends
//   sum     : bitwise sum
//   carry   : majority bits already shifted up one place; the carry out of the
//             top bit is dropped, so the result is a + b + c modulo 2**WIDTH
module carry_save_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    logic [WIDTH-1:0] maj;

    assign sum   = a ^ b ^ c;
    assign maj   = (a & b) | (a & c) | (b & c);
    assign carry = maj << 1;

endmodule

// File: rtl/pp_mul_pipe.sv
// Three-stage pipelined radix-4 Booth multiplier with tag sideband and flush.
//   CLK, RST                 : clock, asynchronous active-high reset
//   in_valid / in_ready      : operation handshake (in_ready = pipeline may advance)
//   multiplicand, multiplier : WIDTH-bit operands (WIDTH even, >= 8)
//   is_signed                : bit1 = multiplicand signed, bit0 = multiplier signed
//   tag_in / tag_out         : opaque ID travelling with its operation
//   flush                    : drops every in-flight operation on the next edge
//   out_valid / out_ready    : result handshake
//   product                  : exact 2*WIDTH-bit product
// Stage 1 holds Booth partial products, stage 2 two carry-save pairs,
// stage 3 the carry-propagated product.
module pp_mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [1:0]           is_signed,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     tag_out
);

    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = WIDTH / 2 + 1;
    localparam int N_LO = NPP / 2;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Operand extension. The multiplier gets two extension bits so an unsigned
    // operand still ends in a non-negative digit, giving WIDTH/2+1 digits.
    sign_mode_e        mode;
    logic              a_sx;
    logic              b_sx;
    logic [PW-1:0]     a_ext;
    logic [WIDTH+2:0]  b_pad;

    assign mode  = sign_mode_e'(is_signed);
    assign a_sx  = a_is_signed(mode) & multiplicand[WIDTH-1];
    assign b_sx  = b_is_signed(mode) & multiplier[WIDTH-1];
    assign a_ext = {{WIDTH{a_sx}}, multiplicand};
    assign b_pad = {b_sx, b_sx, multiplier, 1'b0};

    // Each partial product is fully sign-extended to PW bits, so the tree
    // sum modulo 2**PW is the exact product in every signedness mode.
    logic [PW-1:0] pp_next [NPP];

    for (genvar j = 0; j < NPP; j++) begin : g_booth
        booth_sel_e    sel;
        logic          neg;
        logic [PW-1:0] mag;

        booth_r4_enc u_enc (
            .triplet (b_pad[2*j+2 -: 3]),
            .sel     (sel),
            .neg     (neg)
        );

        always_comb begin
            mag = '0;
            if (sel == BOOTH_ONE) begin
                mag = a_ext;
            end else if (sel == BOOTH_TWO) begin
                mag = a_ext << 1;
            end
        end

        assign pp_next[j] = (neg ? -mag : mag) << (2 * j);
    end

    logic [PW-1:0]    s1_pp [NPP];
    logic [TAG_W-1:0] s1_tag;
    logic             s1_valid;
    logic [PW-1:0]    s2_sum [2];
    logic [PW-1:0]    s2_car [2];
    logic [TAG_W-1:0] s2_tag;
    logic             s2_valid;

    // The partial products are split into two groups, each reduced to a
    // sum/carry pair; those four vectors are the stage-2 mid-point.
    logic [PW-1:0] red_sum [2];
    logic [PW-1:0] red_car [2];

    for (genvar g = 0; g < 2; g++) begin : g_grp
        localparam int BASE = (g == 0) ? 0 : N_LO;
        localparam int CNT  = (g == 0) ? N_LO : NPP - N_LO;

        if (CNT == 2) begin : g_pass
            assign red_sum[g] = s1_pp[BASE];
            assign red_car[g] = s1_pp[BASE+1];
        end else begin : g_chain
            for (genvar i = 0; i < CNT - 2; i++) begin : g_csa
                logic [PW-1:0] s_in;
                logic [PW-1:0] c_in;
                logic [PW-1:0] s_out;
                logic [PW-1:0] c_out;

                if (i == 0) begin : g_head
                    assign s_in = s1_pp[BASE];
                    assign c_in = s1_pp[BASE+1];
                end else begin : g_link
                    assign s_in = g_csa[i-1].s_out;
                    assign c_in = g_csa[i-1].c_out;
                end

                carry_save_adder #(.WIDTH(PW)) u_csa (
                    .a     (s_in),
                    .b     (c_in),
                    .c     (s1_pp[BASE+i+2]),
                    .sum   (s_out),
                    .carry (c_out)
                );
            end

            assign red_sum[g] = g_csa[CNT-3].s_out;
            assign red_car[g] = g_csa[CNT-3].c_out;
        end
    end

    // Stage 3: fold the four mid-point vectors to two, then carry-propagate.
    logic [PW-1:0] f1_sum;
    logic [PW-1:0] f1_car;
    logic [PW-1:0] f2_sum;
    logic [PW-1:0] f2_car;

    carry_save_adder #(.WIDTH(PW)) u_fold1 (
        .a     (s2_sum[0]),
        .b     (s2_car[0]),
        .c     (s2_sum[1]),
        .sum   (f1_sum),
        .carry (f1_car)
    );

    carry_save_adder #(.WIDTH(PW)) u_fold2 (
        .a     (f1_sum),
        .b     (f1_car),
        .c     (s2_car[1]),
        .sum   (f2_sum),
        .carry (f2_car)
    );

    // Valid bits: flush overrides advance, so an input presented with flush is dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int j = 0; j < NPP; j++) begin
                s1_pp[j] <= '0;
            end
            for (int g = 0; g < 2; g++) begin
                s2_sum[g] <= '0;
                s2_car[g] <= '0;
            end
            s1_tag  <= '0;
            s2_tag  <= '0;
            product <= '0;
            tag_out <= '0;
        end else if (adv) begin
            for (int j = 0; j < NPP; j++) begin
                s1_pp[j] <= pp_next[j];
            end
            for (int g = 0; g < 2; g++) begin
                s2_sum[g] <= red_sum[g];
                s2_car[g] <= red_car[g];
            end
            s1_tag  <= tag_in;
            s2_tag  <= s1_tag;
            product <= f2_sum + f2_car;
            tag_out <= s2_tag;
        end
    end

endmodule

// File: tb/tb_pp_mul_pipe.sv
// Directed bench for pp_mul_pipe: a WIDTH=32 instance checked against
// hand-computed products and a WIDTH=16 instance checked against a
// reference multiply.
module tb_pp_mul_pipe;

    localparam logic [1:0] M_UU = 2'b00;
    localparam logic [1:0] M_US = 2'b01;
    localparam logic [1:0] M_SU = 2'b10;
    localparam logic [1:0] M_SS = 2'b11;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic        out_ready;

    logic        in_valid32;
    logic        in_ready32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic [1:0]  mode32;
    logic [3:0]  tag32;
    logic        out_valid32;
    logic [63:0] product32;
    logic [3:0]  tag_out32;

    logic        in_valid16;
    logic        in_ready16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [1:0]  mode16;
    logic [3:0]  tag16;
    logic        out_valid16;
    logic [31:0] product16;
    logic [3:0]  tag_out16;

    int checks = 0;
    int errors = 0;

    pp_mul_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid32),
        .in_ready     (in_ready32),
        .multiplicand (a32),
        .multiplier   (b32),
        .is_signed    (mode32),
        .tag_in       (tag32),
        .flush        (flush),
        .out_valid    (out_valid32),
        .out_ready    (out_ready),
        .product      (product32),
        .tag_out      (tag_out32)
    );

    pp_mul_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid16),
        .in_ready     (in_ready16),
        .multiplicand (a16),
        .multiplier   (b16),
        .is_signed    (mode16),
        .tag_in       (tag16),
        .flush        (flush),
        .out_valid    (out_valid16),
        .out_ready    (out_ready),
        .product      (product16),
        .tag_out      (tag_out16)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] m);
        logic signed [33:0] ea;
        logic signed [33:0] eb;
        logic signed [33:0] p;
        ea = {{18{m[1] & a[15]}}, a};
        eb = {{18{m[0] & b[15]}}, b};
        p  = ea * eb;
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input bit use16, input logic v, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] m,
                                 input logic [3:0] t);
        if (use16) begin
            in_valid16 = v;
            a16        = a[15:0];
            b16        = b[15:0];
            mode16     = m;
            tag16      = t;
        end else begin
            in_valid32 = v;
            a32        = a;
            b32        = b;
            mode32     = m;
            tag32      = t;
        end
    endtask

    task automatic checkOutput(input string name, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", name, observed, expected);
        end
    endtask

    // One isolated operation: accept edge E, nothing after E and E+1,
    // result after E+2, bubble after E+3.
    task automatic singleOp(input string name, input bit use16, input logic [31:0] a,
                            input logic [31:0] b, input logic [1:0] m, input logic [3:0] t,
                            input logic [63:0] expected);
        applyStimulus(use16, 1'b1, a, b, m, t);
        checkOutput({name, "_in_ready"}, use16 ? in_ready16 : in_ready32, 64'd1);
        tick();
        applyStimulus(use16, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
        checkOutput({name, "_lat_e0"}, use16 ? out_valid16 : out_valid32, 64'd0);
        tick();
        checkOutput({name, "_lat_e1"}, use16 ? out_valid16 : out_valid32, 64'd0);
        tick();
        checkOutput({name, "_valid"}, use16 ? out_valid16 : out_valid32, 64'd1);
        checkOutput({name, "_product"}, use16 ? {32'd0, product16} : product32, expected);
        checkOutput({name, "_tag"}, use16 ? tag_out16 : tag_out32, {60'd0, t});
        tick();
        checkOutput({name, "_drop"}, use16 ? out_valid16 : out_valid32, 64'd0);
    endtask

    initial begin
        int          next_in;
        int          next_out;
        int          stall_cycles;
        bit          stalled_prev;
        logic [63:0] held_prod;
        logic [3:0]  held_tag;
        logic [63:0] expv;

        RST       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
        applyStimulus(1'b1, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);

        // Reset state
        @(posedge CLK);
        #1;
        checkOutput("rst_out_valid", out_valid32, 64'd0);
        checkOutput("rst_in_ready", in_ready32, 64'd1);
        checkOutput("rst_product", product32, 64'd0);
        checkOutput("rst_tag_out", tag_out32, 64'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        tick();
        checkOutput("post_rst_out_valid", out_valid32, 64'd0);
        checkOutput("post_rst_in_ready", in_ready32, 64'd1);

        // Directed single operations, WIDTH=32
        singleOp("ss_minneg_x_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, M_SS, 4'd3,
                 64'h0000_0000_8000_0000);
        singleOp("uu_allones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, M_UU, 4'd6,
                 64'hFFFF_FFFE_0000_0001);
        singleOp("su_allones", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, M_SU, 4'd12,
                 64'hFFFF_FFFF_0000_0001);
        singleOp("su_minneg", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, M_SU, 4'd1,
                 64'h8000_0000_8000_0000);
        singleOp("us_2_x_m2", 1'b0, 32'h0000_0002, 32'hFFFF_FFFE, M_US, 4'd2,
                 64'hFFFF_FFFF_FFFF_FFFC);
        singleOp("ss_minneg_sq", 1'b0, 32'h8000_0000, 32'h8000_0000, M_SS, 4'd4,
                 64'h4000_0000_0000_0000);
        singleOp("ss_minneg_x_max", 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, M_SS, 4'd5,
                 64'hC000_0000_8000_0000);
        singleOp("ss_m3_x_7", 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, M_SS, 4'd7,
                 64'hFFFF_FFFF_FFFF_FFEB);
        singleOp("uu_big_x_7", 1'b0, 32'hFFFF_FFFD, 32'h0000_0007, M_UU, 4'd8,
                 64'h0000_0006_FFFF_FFEB);
        singleOp("ss_zero_op", 1'b0, 32'h0000_0000, 32'h8000_0000, M_SS, 4'd9,
                 64'h0000_0000_0000_0000);
        singleOp("ss_neg_x_zero", 1'b0, 32'hFFFF_FFFB, 32'h0000_0000, M_SS, 4'd10,
                 64'h0000_0000_0000_0000);

        // Back-to-back stream of 8 operations, results must be contiguous
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                applyStimulus(1'b0, 1'b1, 32'(k + 1), 32'hFFFF_FFFF, M_SS, 4'(k));
            end else begin
                applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
            end
            tick();
            if (k >= 2) begin
                expv = 64'd0 - 64'(k - 1);
                checkOutput($sformatf("stream_valid_%0d", k - 2), out_valid32, 64'd1);
                checkOutput($sformatf("stream_tag_%0d", k - 2), tag_out32, 64'(k - 2));
                checkOutput($sformatf("stream_prod_%0d", k - 2), product32, expv);
            end
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
        tick();
        checkOutput("stream_drain", out_valid32, 64'd0);

        // Stream with out_ready low for 5 cycles
        next_in      = 0;
        next_out     = 0;
        stall_cycles = 0;
        stalled_prev = 1'b0;
        held_prod    = '0;
        held_tag     = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (next_in < 6) begin
                applyStimulus(1'b0, 1'b1, 32'(next_in + 1), 32'hFFFF_FFFD, M_US,
                              4'(8 + next_in));
            end else begin
                applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
            end
            #1;
            if (out_valid32 && !out_ready) begin
                stall_cycles++;
                checkOutput($sformatf("stall_in_ready_c%0d", cyc), in_ready32, 64'd0);
                if (stalled_prev) begin
                    checkOutput($sformatf("stall_hold_prod_c%0d", cyc), product32, held_prod);
                    checkOutput($sformatf("stall_hold_tag_c%0d", cyc), tag_out32, 64'(held_tag));
                end
                held_prod    = product32;
                held_tag     = tag_out32;
                stalled_prev = 1'b1;
            end else begin
                stalled_prev = 1'b0;
            end
            if (out_valid32 && out_ready) begin
                expv = 64'd0 - 64'(3 * (next_out + 1));
                checkOutput($sformatf("stall_tag_%0d", next_out), tag_out32, 64'(8 + next_out));
                checkOutput($sformatf("stall_prod_%0d", next_out), product32, expv);
                next_out++;
            end
            if (in_valid32 && in_ready32) begin
                next_in++;
            end
            tick();
        end
        out_ready = 1'b1;
        checkOutput("stall_cycle_count", 64'(stall_cycles), 64'd5);
        checkOutput("stall_all_delivered", 64'(next_out), 64'd6);
        checkOutput("stall_no_extra", out_valid32, 64'd0);

        // Flush with two operations in flight and a third presented
        applyStimulus(1'b0, 1'b1, 32'd7, 32'd9, M_UU, 4'd1);
        tick();
        applyStimulus(1'b0, 1'b1, 32'd11, 32'd13, M_UU, 4'd2);
        tick();
        applyStimulus(1'b0, 1'b1, 32'd15, 32'd17, M_UU, 4'd4);
        flush = 1'b1;
        #1;
        checkOutput("flush_in_ready", in_ready32, 64'd1);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("flush_quiet_%0d", k), out_valid32, 64'd0);
            tick();
        end
        singleOp("post_flush", 1'b0, 32'h0000_1000, 32'h0000_1000, M_UU, 4'd5,
                 64'h0000_0000_0100_0000);

        // Reset asserted mid-stream
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 32'(5 + k), 32'd6, M_SS, 4'(9 + k));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, M_UU, 4'd0);
        checkOutput("midrst_pre_valid", out_valid32, 64'd1);
        checkOutput("midrst_pre_prod", product32, 64'd30);
        #2;
        RST = 1'b1;
        #1;
        checkOutput("midrst_out_valid", out_valid32, 64'd0);
        checkOutput("midrst_product", product32, 64'd0);
        checkOutput("midrst_tag_out", tag_out32, 64'd0);
        checkOutput("midrst_in_ready", in_ready32, 64'd1);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("midrst_quiet_%0d", k), out_valid32, 64'd0);
        end

        // WIDTH=16 instance against the reference multiply
        singleOp("w16_ss_minneg_x_m1", 1'b1, 32'h8000, 32'hFFFF, M_SS, 4'd3,
                 {32'd0, ref16(16'h8000, 16'hFFFF, M_SS)});
        singleOp("w16_uu_allones", 1'b1, 32'hFFFF, 32'hFFFF, M_UU, 4'd6,
                 {32'd0, ref16(16'hFFFF, 16'hFFFF, M_UU)});
        singleOp("w16_su_allones", 1'b1, 32'hFFFF, 32'hFFFF, M_SU, 4'd12,
                 {32'd0, ref16(16'hFFFF, 16'hFFFF, M_SU)});
        singleOp("w16_us_3_x_m16", 1'b1, 32'h0003, 32'hFFF0, M_US, 4'd2,
                 {32'd0, ref16(16'h0003, 16'hFFF0, M_US)});
        singleOp("w16_ss_minneg_sq", 1'b1, 32'h8000, 32'h8000, M_SS, 4'd4,
                 {32'd0, ref16(16'h8000, 16'h8000, M_SS)});
        singleOp("w16_ss_max_x_minneg", 1'b1, 32'h7FFF, 32'h8000, M_SS, 4'd5,
                 {32'd0, ref16(16'h7FFF, 16'h8000, M_SS)});
        singleOp("w16_uu_mixed", 1'b1, 32'h1234, 32'hABCD, M_UU, 4'd7,
                 {32'd0, ref16(16'h1234, 16'hABCD, M_UU)});
        singleOp("w16_ss_neg_x_zero", 1'b1, 32'hFFF6, 32'h0000, M_SS, 4'd9,
                 {32'd0, ref16(16'hFFF6, 16'h0000, M_SS)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pp_mul_pipe.md
PP_MUL_PIPE -- requirements
Module: pp_mul_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be even and >= 8.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 Port CLK  input  1  rising-edge clock; the block has one clock.
REQ-004 Port RST  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  operation present on inputs.
REQ-006 Port in_ready  output  1  block accepts the operation this cycle.
REQ-007 Port multiplicand  input  WIDTH  operand A.
REQ-008 Port multiplier  input  WIDTH  operand B.
REQ-009 Port is_signed  input  2  bit1 = A signed, bit0 = B signed.
REQ-010 Port tag_in  input  TAG_W  opaque ID, returned unchanged.
REQ-011 Port flush  input  1  kill all in-flight operations.
REQ-012 Port out_valid  output  1  result valid.
REQ-013 Port out_ready  input  1  consumer accepts the result.
REQ-014 Port product  output  2*WIDTH  full product.
REQ-015 Port tag_out  output  TAG_W  tag of the operation on product.

Function
REQ-016 Datapath SHALL be three register stages: S1 holds the radix-4 Booth partial products (WIDTH/2+1 terms, sign-correct for all is_signed modes), the tag and a valid bit; S2 holds the CSA-tree mid-point; S3 holds the final carry-propagate sum.
REQ-017 An operation SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-018 Latency: an operation accepted on edge E with no stall SHALL show out_valid=1 and its product after edge E+2, i.e. from the third edge onward.
REQ-019 Throughput: one operation per cycle while out_ready=1.
REQ-020 Advance: adv = !out_valid || out_ready; every stage (data and valid) SHALL load only when adv=1; in_ready = adv.
REQ-021 While out_valid && !out_ready, product, tag_out and out_valid SHALL hold stable.
REQ-022 A bubble (valid bit 0) SHALL propagate like data; a bubble at the output drops out_valid.
REQ-023 Product = A*B computed exactly in 2*WIDTH bits, with operand interpretation per is_signed; the 2'b10 (signed*unsigned) mode SHALL be correct.
REQ-024 Boundaries: most-negative signed operand, a zero operand, all-ones unsigned operands, and a negative result equal to 0 SHALL each give the exact product with no stray sign bits.
REQ-025 flush=1 SHALL clear all stage valid bits on that edge, regardless of adv; data registers may keep stale values.
REQ-026 flush and a simultaneous in_valid: flush wins and the input is dropped; in_ready is unaffected by flush.
REQ-027 tag_out SHALL travel in lockstep with its product.

Reset
REQ-028 RST=1 SHALL asynchronously clear all valid bits, product and tag_out to 0; out_valid=0 and in_ready=1 during and after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight operations; no result is emitted for them after release.

Structure
REQ-030 Shared package mul_pkg SHALL hold the sign-mode enum (UU=00, US=01, SU=10, SS=11), the Booth select encoding and the MUL_LATENCY=3 constant.
REQ-031 Booth recoding SHALL be a sub-module booth_r4_enc (one digit: 3 multiplier bits in, select/negate out); the existing carry_save_adder SHALL be reused for the tree.

Verification
REQ-032 WIDTH=32, SS, A=0x80000000, B=0xFFFFFFFF, tag=3, out_ready=1 -> product 0x0000000080000000, tag_out=3, out_valid exactly 3 edges after accept.
REQ-033 UU, A=B=0xFFFFFFFF -> product 0xFFFFFFFE00000001; SU, A=0xFFFFFFFF, B=0xFFFFFFFF -> product 0xFFFFFFFF00000001.
REQ-034 Back-to-back stream of 8 ops with tags 0..7 and out_ready=1 -> 8 consecutive out_valid cycles, tags in order, no bubbles.
REQ-035 out_ready low for 5 cycles during a stream -> in_ready=0 while the output is stalled, output held stable, no loss or duplication after release.
REQ-036 flush pulsed with 2 ops in flight plus in_valid=1 the same cycle -> no out_valid for any of the 3; next accepted op completes normally.
REQ-037 RST asserted mid-stream, then released -> outputs 0 immediately, no stale results; WIDTH=16 rerun of REQ-032/033 against a reference model.
